// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: two 4x4 operand banks plus a row-major sequencer driving one dot-product PE.
// Define FEEDER_PERF_CNT_EN to add the saturating backpressure counter output stall_cnt.
//
// state | meaning
// IDLE  | waiting for start; operand writes accepted
// RUN   | pe_en high for HOLD cycles on the current element
// OUT   | result presented on the output stream, waiting for res_ready
module pe_operand_feeder #(
   parameter int HOLD = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_sel,
   input  logic [3:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        start,
   output logic        pe_en,
   output logic [63:0] pe_a,
   output logic [63:0] pe_b,
   input  logic [15:0] pe_c,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [1:0]  res_row,
   output logic [1:0]  res_col,
   output logic        busy,
   output logic        done,
   output logic        wr_err
`ifdef FEEDER_PERF_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(HOLD - 1);

   state_t      state;
   logic [15:0] mem_a  [16];
   logic [15:0] mem_b  [16];
   logic [15:0] view_a [16];
   logic [15:0] view_b [16];
   logic [3:0]  idx;
   logic [3:0]  ld_idx;
   logic [7:0]  cnt;
   logic [63:0] nxt_a;
   logic [63:0] nxt_b;
   logic        wr_ok;

   assign wr_ok = wr_en && (state == S_IDLE);

   // Operand storage deliberately has no reset; contents persist across multiplies.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         if (wr_sel)
            mem_b[wr_addr] <= wr_data;
         else
            mem_a[wr_addr] <= wr_data;
      end
   end

   // Forward a same-cycle write so a start coinciding with a write sees the new value.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         view_a[k] = mem_a[k];
         view_b[k] = mem_b[k];
      end
      if (wr_ok && !wr_sel)
         view_a[wr_addr] = wr_data;
      if (wr_ok && wr_sel)
         view_b[wr_addr] = wr_data;
   end

   assign ld_idx = (state == S_IDLE) ? 4'd0 : idx + 4'd1;

   assign nxt_a = {view_a[{ld_idx[3:2], 2'd0}], view_a[{ld_idx[3:2], 2'd1}],
                   view_a[{ld_idx[3:2], 2'd2}], view_a[{ld_idx[3:2], 2'd3}]};
   assign nxt_b = {view_b[{2'd0, ld_idx[1:0]}], view_b[{2'd1, ld_idx[1:0]}],
                   view_b[{2'd2, ld_idx[1:0]}], view_b[{2'd3, ld_idx[1:0]}]};

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= 4'd0;
         cnt       <= 8'd0;
         pe_en     <= 1'b0;
         pe_a      <= 64'd0;
         pe_b      <= 64'd0;
         res_valid <= 1'b0;
         res_data  <= 16'd0;
         res_row   <= 2'd0;
         res_col   <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_en && state != S_IDLE)
            wr_err <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  idx   <= 4'd0;
                  cnt   <= 8'd0;
                  pe_en <= 1'b1;
                  busy  <= 1'b1;
                  pe_a  <= nxt_a;
                  pe_b  <= nxt_b;
               end
            end
            S_RUN: begin
               if (cnt == CNT_LAST) begin
                  res_data  <= pe_c;
                  res_row   <= idx[3:2];
                  res_col   <= idx[1:0];
                  pe_en     <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (idx == 4'd15) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + 4'd1;
                     cnt   <= 8'd0;
                     pe_en <= 1'b1;
                     pe_a  <= nxt_a;
                     pe_b  <= nxt_b;
                     state <= S_RUN;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FEEDER_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (reset)
         stall_cnt <= 16'd0;
      else if (state == S_IDLE && start)
         stall_cnt <= 16'd0;
      else if (res_valid && !res_ready && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder with a behavioural PE whose result is only valid
// from the HOLD-th consecutive cycle of en.
module tb_pe_operand_feeder;
   localparam int HOLD = 8;

   logic        CLK;
   logic        reset;
   logic        wr_en;
   logic        wr_sel;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        start;
   logic        pe_en;
   logic [63:0] pe_a;
   logic [63:0] pe_b;
   logic [15:0] pe_c;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [1:0]  res_row;
   logic [1:0]  res_col;
   logic        busy;
   logic        done;
   logic        wr_err;
`ifdef FEEDER_PERF_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pe_operand_feeder #(.HOLD(HOLD)) dut (
      .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b),
      .pe_c(pe_c), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_row(res_row), .res_col(res_col), .busy(busy), .done(done), .wr_err(wr_err)
`ifdef FEEDER_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // PE model: result appears only once en has been high for HOLD cycles in a row.
   int en_run;
   always @(posedge CLK) begin
      if (reset || !pe_en)
         en_run <= 0;
      else
         en_run <= en_run + 1;
   end

   function automatic logic [15:0] dot(input logic [63:0] a, input logic [63:0] b);
      int s;
      s = 0;
      for (int k = 0; k < 4; k++)
         s += int'($signed(a[k*16 +: 16])) * int'($signed(b[k*16 +: 16]));
      return s[15:0];
   endfunction

   always_comb begin
      pe_c = 16'hDEAD;
      if (pe_en && en_run >= HOLD - 1)
         pe_c = dot(pe_a, pe_b);
   end

   logic [15:0] got_data [16];
   logic [1:0]  got_row  [16];
   logic [1:0]  got_col  [16];
   int          n_got;
   int          done_cyc;
   int          first_valid;
   int          stall_bad;
   logic        pe_en_c1;
   logic        busy_at_done;

   task automatic write_entry(input logic sel, input logic [3:0] addr, input logic [15:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      @(posedge CLK); #1;
      wr_en = 1'b0;
   endtask

   // pat 0: A identity, B[r][c]=4r+c+1; pat 1: A=2, B=3; pat 2: A row0=-1, B col0=100
   task automatic load_pattern(input int pat);
      logic [15:0] va, vb;
      int r, c;
      for (int a = 0; a < 16; a++) begin
         r = a / 4;
         c = a % 4;
         case (pat)
            0: begin va = (r == c) ? 16'd1 : 16'd0; vb = 16'(a + 1); end
            1: begin va = 16'd2; vb = 16'd3; end
            default: begin va = (r == 0) ? 16'hFFFF : 16'd0; vb = (c == 0) ? 16'd100 : 16'd0; end
         endcase
         write_entry(1'b0, 4'(a), va);
         write_entry(1'b1, 4'(a), vb);
      end
   endtask

   // Runs one multiply from a start pulse; wr_* already set by the caller stays on for the start cycle.
   task automatic run_mult(input int stall_idx, input int stall_len, input int inject_cyc);
      int cyc, left;
      logic [15:0] hd;
      logic [1:0] hr, hc;
      bit held;
      n_got = 0; done_cyc = -1; first_valid = -1; stall_bad = 0; busy_at_done = 1'b1;
      left = stall_len; held = 0; hd = '0; hr = '0; hc = '0;
      res_ready = 1'b1;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; wr_en = 1'b0;
      cyc = 1;
      pe_en_c1 = pe_en;
      while (cyc < 600) begin
         if (cyc == inject_cyc) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'h7777;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (done) begin
            done_cyc = cyc;
            busy_at_done = busy;
            break;
         end
         if (res_valid && first_valid < 0)
            first_valid = cyc;
         res_ready = 1'b1;
         if (res_valid && n_got == stall_idx && left > 0) begin
            if (held && (res_data !== hd || res_row !== hr || res_col !== hc)) stall_bad = 1;
            if (pe_en) stall_bad = 1;
            hd = res_data; hr = res_row; hc = res_col; held = 1;
            res_ready = 1'b0;
            left--;
         end
         if (res_valid && res_ready) begin
            if (held && n_got == stall_idx && (res_data !== hd || res_row !== hr || res_col !== hc))
               stall_bad = 1;
            if (n_got < 16) begin
               got_data[n_got] = res_data;
               got_row[n_got]  = res_row;
               got_col[n_got]  = res_col;
            end
            n_got++;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      start = 1'b0; wr_en = 1'b0; res_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b0;
      checks++;
      if ({pe_en, res_valid, busy, done, wr_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00000", {pe_en, res_valid, busy, done, wr_err});
      end
      checks++;
      if ({res_data, res_row, res_col} !== 20'd0) begin
         errors++;
         $display("FAIL reset_result got %h exp 0", {res_data, res_row, res_col});
      end
      checks++;
      if ({pe_a, pe_b} !== 128'd0) begin
         errors++;
         $display("FAIL reset_operands got %h exp 0", {pe_a, pe_b});
      end
   endtask

   task automatic test_identity;
      load_pattern(0);
      run_mult(-1, 0, -1);
      checks++;
      if (pe_en_c1 !== 1'b1) begin errors++; $display("FAIL t1_pe_en_c1 got %b exp 1", pe_en_c1); end
      checks++;
      if (first_valid != HOLD + 1) begin
         errors++; $display("FAIL t1_first_valid got %0d exp %0d", first_valid, HOLD + 1);
      end
      checks++;
      if (n_got != 16) begin errors++; $display("FAIL t1_count got %0d exp 16", n_got); end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (got_data[e] !== 16'(e + 1) || got_row[e] !== 2'(e / 4) || got_col[e] !== 2'(e % 4)) begin
            errors++;
            $display("FAIL t1_elem[%0d] got %h (%0d,%0d) exp %h (%0d,%0d)", e, got_data[e],
                     got_row[e], got_col[e], 16'(e + 1), e / 4, e % 4);
         end
      end
      checks++;
      if (done_cyc != 16 * (HOLD + 1) + 1) begin
         errors++; $display("FAIL t1_done_cycle got %0d exp %0d", done_cyc, 16 * (HOLD + 1) + 1);
      end
      checks++;
      if (busy_at_done !== 1'b0) begin errors++; $display("FAIL t1_busy_at_done got %b exp 0", busy_at_done); end
      @(posedge CLK); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse_width got %b exp 0", done); end
   endtask

   task automatic test_all_twos;
      load_pattern(1);
      run_mult(-1, 0, -1);
      checks++;
      if (n_got != 16) begin errors++; $display("FAIL t2_count got %0d exp 16", n_got); end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (got_data[e] !== 16'h0018) begin
            errors++; $display("FAIL t2_data[%0d] got %h exp 0018", e, got_data[e]);
         end
      end
   endtask

   task automatic test_negative;
      logic [15:0] exp;
      load_pattern(2);
      run_mult(-1, 0, -1);
      for (int e = 0; e < 16; e++) begin
         exp = (e == 0) ? 16'hFE70 : 16'h0000;
         checks++;
         if (got_data[e] !== exp) begin
            errors++; $display("FAIL t3_data[%0d] got %h exp %h", e, got_data[e], exp);
         end
      end
   endtask

   task automatic test_backpressure;
      load_pattern(0);
      run_mult(3, 5, -1);
      checks++;
      if (stall_bad != 0) begin errors++; $display("FAIL t4_stall_stable got %0d exp 0", stall_bad); end
      checks++;
      if (done_cyc != 16 * (HOLD + 1) + 6) begin
         errors++; $display("FAIL t4_done_cycle got %0d exp %0d", done_cyc, 16 * (HOLD + 1) + 6);
      end
      checks++;
      if (n_got != 16) begin errors++; $display("FAIL t4_count got %0d exp 16", n_got); end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (got_data[e] !== 16'(e + 1)) begin
            errors++; $display("FAIL t4_data[%0d] got %h exp %h", e, got_data[e], 16'(e + 1));
         end
      end
`ifdef FEEDER_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 16'd5) begin errors++; $display("FAIL t4_stall_cnt got %0d exp 5", stall_cnt); end
`endif
   endtask

   task automatic test_start_write;
      load_pattern(0);
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 16'd50;
      run_mult(-1, 0, -1);
      checks++;
      if (got_data[0] !== 16'd50) begin errors++; $display("FAIL tsw_elem0 got %h exp 0032", got_data[0]); end
      checks++;
      if (got_data[1] !== 16'd2) begin errors++; $display("FAIL tsw_elem1 got %h exp 0002", got_data[1]); end
   endtask

   task automatic test_busy_write;
      load_pattern(0);
      run_mult(-1, 0, 20);
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL t5_wr_err got %b exp 1", wr_err); end
      checks++;
      if (n_got != 16 || done_cyc != 16 * (HOLD + 1) + 1) begin
         errors++; $display("FAIL t5_run got %0d results done %0d exp 16 done %0d", n_got, done_cyc,
                            16 * (HOLD + 1) + 1);
      end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (got_data[e] !== 16'(e + 1)) begin
            errors++; $display("FAIL t5_data[%0d] got %h exp %h", e, got_data[e], 16'(e + 1));
         end
      end
      run_mult(-1, 0, -1);
      checks++;
      if (got_data[0] !== 16'd1) begin errors++; $display("FAIL t5_bank_kept got %h exp 0001", got_data[0]); end
   endtask

   task automatic test_reset_mid;
      int saw_done;
      load_pattern(0);
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (65) begin @(posedge CLK); #1; end
      checks++;
      if (pe_en !== 1'b1) begin errors++; $display("FAIL t6_in_run got pe_en %b exp 1", pe_en); end
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      checks++;
      if ({pe_en, res_valid, busy, done, wr_err, res_row, res_col, res_data, pe_a, pe_b} !== 153'd0) begin
         errors++;
         $display("FAIL t6_outputs_zero got %b%b%b%b%b data %h exp all 0", pe_en, res_valid, busy, done,
                  wr_err, res_data);
      end
      saw_done = 0;
      repeat (20) begin
         if (done || busy) saw_done = 1;
         @(posedge CLK); #1;
      end
      checks++;
      if (saw_done != 0) begin errors++; $display("FAIL t6_no_done got %0d exp 0", saw_done); end
      run_mult(-1, 0, -1);
      checks++;
      if (n_got != 16 || done_cyc != 16 * (HOLD + 1) + 1) begin
         errors++; $display("FAIL t6_rerun got %0d results done %0d", n_got, done_cyc);
      end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (got_data[e] !== 16'(e + 1)) begin
            errors++; $display("FAIL t6_data[%0d] got %h exp %h", e, got_data[e], 16'(e + 1));
         end
      end
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
      start = 1'b0; res_ready = 1'b1;
      test_reset();
      test_identity();
      test_all_twos();
      test_negative();
      test_backpressure();
      test_start_write();
      test_busy_write();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_operand_feeder.md
# pe_operand_feeder

Upstream sequencer for the 4-term dot-product PE. It holds two 4x4 matrices of signed 16-bit operands loaded over a simple write port and issues all 16 row/column pairs to one PE in row-major order, controlling the PE's `en`. It captures each 16-bit PE result and presents it on a valid/ready output stream tagged with row and column. Together, the feeder and one PE perform a full 4x4 matrix multiply, C = A·B.

## Interface
- `HOLD`, default 8: number of cycles `pe_en` stays high per element. Must be at least the PE's en-to-valid latency. Legal range 2..255.
- `CLK` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: operand write strobe.
- `wr_sel` in 1: bank select. 0 = A, 1 = B.
- `wr_addr` in 4: {row[1:0], col[1:0]}.
- `wr_data` in 16: signed operand.
- `start` in 1: single-cycle pulse that begins a multiply.
- `pe_en` out 1: drives the PE `en` input.
- `pe_a` out 64: drives the PE `A` input.
- `pe_b` out 64: drives the PE `B` input.
- `pe_c` in 16: PE result.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out 16: captured result.
- `res_row` out 2, `res_col` out 2: index of the current result.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after element 15 is accepted.
- `wr_err` out 1: sticky flag set by a write attempted while busy. Cleared only by reset.

## Operation
- **Storage:** two banks of 16x16-bit registers.
  - Storage is not affected by reset; contents persist across multiplies.
  - A write with `wr_en=1` while IDLE updates the addressed entry on the next edge.
  - A write while `busy=1` is dropped and sets `wr_err`.
- **Element index:** `idx` is 4 bits. i = `idx[3:2]`, j = `idx[1:0]`.
- **Operand packing:**
  - `pe_a = {A[i][0], A[i][1], A[i][2], A[i][3]}`, with A[i][0] in bits [63:48].
  - `pe_b = {B[0][j], B[1][j], B[2][j], B[3][j]}`.
  - Both are registered and updated when `idx` changes. They are stable throughout RUN.
- **FSM states:** IDLE, RUN, OUT.
  - IDLE: `start=1` → RUN, with `idx=0` and `cnt=0`. `start` in any other state is ignored.
  - RUN: `pe_en=1` and `cnt` increments each cycle. In the cycle where `cnt==HOLD-1`, `res_data <= pe_c`, `res_row/res_col <= i/j`, then → OUT.
  - OUT: `pe_en=0` and `res_valid=1`. The result fields hold until `res_ready=1`. On acceptance, if `idx==15`, go to IDLE and pulse `done`; otherwise `idx++`, `cnt=0`, → RUN.
- **PE restart:** `pe_en` is low for at least one cycle between elements, via OUT. This restarts the PE's internal stage pipeline.
- **Arithmetic:** no arithmetic is performed in the feeder. `res_data` is `pe_c` bit-exact, i.e. the PE's wrapped 16-bit two's-complement result.
- **Reset:**
  - Clears the FSM to IDLE and clears `idx`, `cnt`, `pe_en`, `pe_a`, `pe_b`, `res_valid`, `res_data`, `res_row`, `res_col`, `busy`, `done` and `wr_err` to 0.
  - Reset mid-operation abandons the multiply without a `done` pulse. `pe_en` drops on the next edge.

## Timing
- `start` is sampled at edge 0. `pe_en` is high from cycle 1 through cycle HOLD. `res_valid` rises in cycle HOLD+1.
- With `res_ready` held at 1, each element takes HOLD+1 cycles. A full matrix takes 16·(HOLD+1) cycles, e.g. 144 cycles at HOLD=8.
- `done` is asserted in the cycle after the accepting handshake of element 15. `busy` falls in the same cycle.
- `pe_c` is sampled in the HOLD-th high cycle of `pe_en`.
- Backpressure adds exactly one cycle per stalled cycle. No result is lost or duplicated.
- `start` and `wr_en` asserted in the same IDLE cycle: the write is applied and the multiply uses the new value.

## Configuration
- **Macro:** `FEEDER_PERF_CNT_EN`.
- **When defined:**
  - Adds output `stall_cnt` (out, 16 bits).
  - `stall_cnt` increments every cycle with `res_valid=1 && res_ready=0` and saturates at 0xFFFF.
  - It is cleared by reset and on `start` accepted in IDLE.
- **When undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
1. Load A = identity and B[r][c] = 4r+c+1, then pulse `start` with `res_ready=1`. The bench must see 16 results in order (0,0)..(3,3) with data 1..16, and `done` at cycle 16·(HOLD+1)+1.
2. Load A all 2 and B all 3. Every `res_data` must be 24 (0x0018).
3. Load A[0][*] = -1 and B[*][0] = 100, with all other entries 0. Result (0,0) must be 0xFE70 (-400); every other result must be 0.
4. Hold `res_ready=0` for 5 cycles on element 3.
   - Fields stay stable and `pe_en` stays low throughout.
   - Total latency grows by 5.
   - With `FEEDER_PERF_CNT_EN` defined, `stall_cnt=5`.
5. Assert `start` and `wr_en` while busy. The multiply is unaffected, `wr_err=1`, and the bank entry is unchanged.
6. Assert `reset` during RUN of element 7.
   - The next cycle shows all outputs 0 and no `done`.
   - A subsequent `start` reproduces the scenario 1 results, since storage is retained.
